// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
// Shared definitions for the bus arbiter slice: FSM state and bus owner
// encodings plus the mem_size access-width codes.
`timescale 1ns/1ps

package bus_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_MEM   = 1'b1
  } owner_t;

  // Size code 3 is treated as a word access, same as SIZE_WORD.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/bus_arbiter_lane_align.sv
// bus_lane_align
// Purely combinational byte-lane helper.
//   Store side: replicates right-aligned store data across the word and
//   builds the byte strobe from the low address bits and the access size.
//   Load side: picks the byte/half lane out of the read word and zero- or
//   sign-extends it; word loads pass straight through.
// Ports:
//   store_addr_lo  in  2   low address bits of the store
//   store_size     in  2   access size code
//   store_data     in  32  right-aligned store data
//   write_data     out 32  lane-replicated store data
//   write_strobe   out 4   byte enables
//   load_addr_lo   in  2   low address bits of the load
//   load_size      in  2   access size code
//   load_signed    in  1   sign-extend narrow loads
//   read_word      in  32  raw word from the bus
//   load_result    out 32  extracted and extended load value
`timescale 1ns/1ps

module bus_lane_align
  import bus_arbiter_pkg::*;
(
  input  logic [1:0]  store_addr_lo,
  input  logic [1:0]  store_size,
  input  logic [31:0] store_data,
  output logic [31:0] write_data,
  output logic [3:0]  write_strobe,
  input  logic [1:0]  load_addr_lo,
  input  logic [1:0]  load_size,
  input  logic        load_signed,
  input  logic [31:0] read_word,
  output logic [31:0] load_result
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Store formatting: misaligned halves are forced onto the half boundary
  // by ignoring address bit 0.
  always_comb begin
    write_data   = store_data;
    write_strobe = 4'hF;
    case (store_size)
      SIZE_BYTE: begin
        write_data   = {4{store_data[7:0]}};
        write_strobe = 4'b0001 << store_addr_lo;
      end
      SIZE_HALF: begin
        write_data   = {2{store_data[15:0]}};
        write_strobe = 4'b0011 << {store_addr_lo[1], 1'b0};
      end
      default: begin
        write_data   = store_data;
        write_strobe = 4'hF;
      end
    endcase
  end

  // Load formatting: lane select first, then extension by size.
  always_comb begin
    load_byte   = read_word[7:0];
    load_half   = load_addr_lo[1] ? read_word[31:16] : read_word[15:0];
    load_result = read_word;
    case (load_addr_lo)
      2'd0:    load_byte = read_word[7:0];
      2'd1:    load_byte = read_word[15:8];
      2'd2:    load_byte = read_word[23:16];
      default: load_byte = read_word[31:24];
    endcase
    case (load_size)
      SIZE_BYTE: load_result = load_signed ? {{24{load_byte[7]}}, load_byte}
                                           : {24'h0, load_byte};
      SIZE_HALF: load_result = load_signed ? {{16{load_half[15]}}, load_half}
                                           : {16'h0, load_half};
      default:   load_result = read_word;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Arbitrates the pipeline's fetch and data-memory request ports onto one
// external valid/ready word bus. Requests are level-held; each port keeps
// a tag of the request it last issued and a done flag, and reports ready
// while the live request still matches the completed tag. Mem beats fetch.
// Optional watchdog: define BUS_ARBITER_TIMEOUT_EN to abort a bus cycle
// left unanswered for TIMEOUT_CYCLES cycles (completes with data 0 and
// pulses bus_error). Without it the bus waits forever and bus_error is 0.
// Ports:
//   clk, reset (async, active-low)
//   fetch_address/fetch_data/fetch_ready          instruction port
//   mem_address/mem_store_data/mem_size/mem_signed/mem_load/mem_store,
//   mem_load_data/mem_ready                       data port
//   ext_valid/ext_address/ext_write/ext_write_data/ext_write_strobe,
//   ext_ready/ext_read_data                       external word bus
//   bus_error                                     watchdog abort pulse
`timescale 1ns/1ps

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_address,
  output logic [31:0] fetch_data,
  output logic        fetch_ready,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic        mem_load,
  input  logic        mem_store,
  output logic [31:0] mem_load_data,
  output logic        mem_ready,
  output logic        ext_valid,
  output logic [31:0] ext_address,
  output logic        ext_write,
  output logic [31:0] ext_write_data,
  output logic [3:0]  ext_write_strobe,
  input  logic        ext_ready,
  input  logic [31:0] ext_read_data,
  output logic        bus_error
);

  state_t      state, next_state;
  owner_t      owner;

  logic [31:0] fetch_tag;
  logic        fetch_done;

  logic [31:0] mem_tag_address;
  logic [31:0] mem_tag_data;
  logic [1:0]  mem_tag_size;
  logic        mem_tag_signed;
  logic        mem_tag_load;
  logic        mem_tag_store;
  logic        mem_done;

  logic        fetch_match, mem_match;
  logic        fetch_pending, mem_pending;
  logic        grant_fetch, grant_mem;
  logic        bus_done, wd_abort;

  logic [31:0] align_write_data;
  logic [3:0]  align_write_strobe;
  logic [31:0] align_load_result;

  // The store side formats the live request (it is captured in IDLE); the
  // load side formats from the tag because the request may have moved on.
  bus_lane_align u_align (
    .store_addr_lo (mem_address[1:0]),
    .store_size    (mem_size),
    .store_data    (mem_store_data),
    .write_data    (align_write_data),
    .write_strobe  (align_write_strobe),
    .load_addr_lo  (mem_tag_address[1:0]),
    .load_size     (mem_tag_size),
    .load_signed   (mem_tag_signed),
    .read_word     (ext_read_data),
    .load_result   (align_load_result)
  );

  // Tag comparison: a port is ready only while its live request equals the
  // request that completed, so a changed request is never acknowledged
  // with a stale result.
  assign fetch_match = (fetch_tag == fetch_address);
  assign mem_match   = (mem_tag_address == mem_address) &&
                       (mem_tag_size    == mem_size) &&
                       (mem_tag_signed  == mem_signed) &&
                       (mem_tag_load    == mem_load) &&
                       (mem_tag_store   == mem_store) &&
                       (mem_tag_data    == mem_store_data);

  assign fetch_pending = !(fetch_done && fetch_match);
  assign mem_pending   = (mem_load || mem_store) && !(mem_done && mem_match);

  assign fetch_ready = fetch_done && fetch_match;
  assign mem_ready   = mem_done && mem_match;

  assign bus_done = (state == ST_BUS) && (ext_ready || wd_abort);

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] wd_count;

  assign wd_abort = ext_valid && !ext_ready && (wd_count == WD_LAST);

  // Watchdog counts consecutive unanswered bus cycles and restarts
  // whenever the bus is answered, idle, or just aborted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_count  <= '0;
      bus_error <= 1'b0;
    end else begin
      bus_error <= wd_abort;
      if (ext_valid && !ext_ready && !wd_abort)
        wd_count <= wd_count + 32'd1;
      else
        wd_count <= '0;
    end
  end
`else
  assign wd_abort  = 1'b0;
  assign bus_error = 1'b0;
`endif

  // State register for the IDLE/BUS controller.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  // Next-state and grant decode: in IDLE the mem port wins over fetch;
  // BUS is left as soon as the handshake (or a watchdog abort) completes.
  always_comb begin
    next_state  = state;
    grant_mem   = 1'b0;
    grant_fetch = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_pending) begin
          grant_mem  = 1'b1;
          next_state = ST_BUS;
        end else if (fetch_pending) begin
          grant_fetch = 1'b1;
          next_state  = ST_BUS;
        end
      end
      ST_BUS: begin
        if (bus_done)
          next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath: capture request tags and bus outputs on a grant, hold them
  // through BUS, then latch the result and mark the owner done. A store
  // that hits the word of the fetch tag clears fetch_done so modified code
  // is fetched again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner            <= OWN_FETCH;
      fetch_tag        <= '0;
      fetch_done       <= 1'b0;
      fetch_data       <= '0;
      mem_tag_address  <= '0;
      mem_tag_data     <= '0;
      mem_tag_size     <= SIZE_BYTE;
      mem_tag_signed   <= 1'b0;
      mem_tag_load     <= 1'b0;
      mem_tag_store    <= 1'b0;
      mem_done         <= 1'b0;
      mem_load_data    <= '0;
      ext_valid        <= 1'b0;
      ext_address      <= '0;
      ext_write        <= 1'b0;
      ext_write_data   <= '0;
      ext_write_strobe <= '0;
    end else begin
      if (grant_mem) begin
        owner            <= OWN_MEM;
        mem_tag_address  <= mem_address;
        mem_tag_data     <= mem_store_data;
        mem_tag_size     <= mem_size;
        mem_tag_signed   <= mem_signed;
        mem_tag_load     <= mem_load;
        mem_tag_store    <= mem_store;
        mem_done         <= 1'b0;
        ext_valid        <= 1'b1;
        ext_address      <= {mem_address[31:2], 2'b00};
        ext_write        <= mem_store;
        ext_write_data   <= mem_store ? align_write_data : 32'h0;
        ext_write_strobe <= mem_store ? align_write_strobe : 4'h0;
      end else if (grant_fetch) begin
        owner            <= OWN_FETCH;
        fetch_tag        <= fetch_address;
        fetch_done       <= 1'b0;
        ext_valid        <= 1'b1;
        ext_address      <= {fetch_address[31:2], 2'b00};
        ext_write        <= 1'b0;
        ext_write_data   <= 32'h0;
        ext_write_strobe <= 4'h0;
      end

      if (bus_done) begin
        ext_valid        <= 1'b0;
        ext_write        <= 1'b0;
        ext_write_data   <= 32'h0;
        ext_write_strobe <= 4'h0;
        if (owner == OWN_FETCH) begin
          fetch_data <= wd_abort ? 32'h0 : ext_read_data;
          fetch_done <= 1'b1;
        end else begin
          if (wd_abort)
            mem_load_data <= 32'h0;
          else if (mem_tag_load && !mem_tag_store)
            mem_load_data <= align_load_result;
          mem_done <= 1'b1;
          if (mem_tag_store && (mem_tag_address[31:2] == fetch_tag[31:2]))
            fetch_done <= 1'b0;
        end
      end
    end
  end

endmodule
